// File: rtl/screen_rect_scanner_pkg.sv
// Shared types and screen defaults for the rectangle scanner and its offset counter.
package screen_rect_scanner_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int SCREEN_W_DEFAULT     = 160;
  localparam int SCREEN_H_DEFAULT     = 120;
  localparam int COLOUR_WIDTH_DEFAULT = 3;

endpackage

// File: rtl/screen_rect_scanner_counter.sv
// Row-major 2D offset counter: x offset runs fastest, wrapping into the next row at x_range.
module rect_scan_counter
  import screen_rect_scanner_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [WIDTH-1:0] x_range,
  input  logic [WIDTH-1:0] y_range,
  output logic [WIDTH-1:0] ox,
  output logic [WIDTH-1:0] oy,
  output logic             last
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] ox_q, ox_d;
  logic [WIDTH-1:0] oy_q, oy_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end

  always_comb begin
    ox_d = ox_q;
    oy_d = oy_q;
    if (clear) begin
      ox_d = '0;
      oy_d = '0;
    end else if (advance) begin
      if (ox_q == x_range) begin
        ox_d = '0;
        oy_d = oy_q + ONE;
      end else begin
        ox_d = ox_q + ONE;
      end
    end
  end

  assign ox   = ox_q;
  assign oy   = oy_q;
  assign last = (ox_q == x_range) && (oy_q == y_range);

endmodule

// File: rtl/screen_rect_scanner.sv
// Raster-scans a latched rectangle: read old colour, show it to the client, write back its new colour.
module screen_rect_scanner
  import screen_rect_scanner_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = COLOUR_WIDTH_DEFAULT,
  parameter int SCREEN_W     = SCREEN_W_DEFAULT,
  parameter int SCREEN_H     = SCREEN_H_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    screen_start,
  input  logic [COLOUR_WIDTH-1:0] new_screen_colour,
  input  logic [WIDTH-1:0]        screen_x_min,
  input  logic [WIDTH-1:0]        screen_y_min,
  input  logic [WIDTH-1:0]        screen_x_range,
  input  logic [WIDTH-1:0]        screen_y_range,
  output logic [WIDTH-1:0]        screen_x,
  output logic [WIDTH-1:0]        screen_y,
  output logic [COLOUR_WIDTH-1:0] old_screen_colour,
  output logic                    screen_done,
  output logic                    busy,
  output logic                    fb_rd_en,
  output logic [WIDTH-1:0]        fb_rd_x,
  output logic [WIDTH-1:0]        fb_rd_y,
  input  logic [COLOUR_WIDTH-1:0] fb_rd_data,
  output logic                    fb_wr_en,
  output logic [WIDTH-1:0]        fb_wr_x,
  output logic [WIDTH-1:0]        fb_wr_y,
  output logic [COLOUR_WIDTH-1:0] fb_wr_colour
);

  localparam logic [WIDTH:0] X_LIMIT = (WIDTH+1)'(SCREEN_W);
  localparam logic [WIDTH:0] Y_LIMIT = (WIDTH+1)'(SCREEN_H);

  state_e state_q, state_d;
  logic [WIDTH-1:0] x_min_q, x_min_d;
  logic [WIDTH-1:0] y_min_q, y_min_d;
  logic [WIDTH-1:0] x_range_q, x_range_d;
  logic [WIDTH-1:0] y_range_q, y_range_d;
  logic [WIDTH-1:0] screen_x_q, screen_x_d;
  logic [WIDTH-1:0] screen_y_q, screen_y_d;

  logic [WIDTH-1:0] ox, oy;
  logic             last;
  logic             clear;
  logic             advance;
  logic [WIDTH:0]   cur_x, cur_y;
  logic             in_screen;

  rect_scan_counter #(.WIDTH(WIDTH)) u_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (advance),
    .x_range (x_range_q),
    .y_range (y_range_q),
    .ox      (ox),
    .oy      (oy),
    .last    (last)
  );

  // One extra bit so a rectangle running past coordinate 2^WIDTH-1 is clipped, not wrapped onto the screen.
  assign cur_x = {1'b0, x_min_q} + {1'b0, ox};
  assign cur_y = {1'b0, y_min_q} + {1'b0, oy};
  assign in_screen = !cur_x[WIDTH] && !cur_y[WIDTH] && (cur_x < X_LIMIT) && (cur_y < Y_LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_min_q    <= '0;
      y_min_q    <= '0;
      x_range_q  <= '0;
      y_range_q  <= '0;
      screen_x_q <= '0;
      screen_y_q <= '0;
    end else begin
      state_q    <= state_d;
      x_min_q    <= x_min_d;
      y_min_q    <= y_min_d;
      x_range_q  <= x_range_d;
      y_range_q  <= y_range_d;
      screen_x_q <= screen_x_d;
      screen_y_q <= screen_y_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    x_min_d           = x_min_q;
    y_min_d           = y_min_q;
    x_range_d         = x_range_q;
    y_range_d         = y_range_q;
    screen_x_d        = screen_x_q;
    screen_y_d        = screen_y_q;
    clear             = 1'b0;
    advance           = 1'b0;
    screen_x          = screen_x_q;
    screen_y          = screen_y_q;
    old_screen_colour = '0;
    screen_done       = 1'b0;
    busy              = (state_q != S_IDLE);
    fb_rd_en          = 1'b0;
    fb_rd_x           = '0;
    fb_rd_y           = '0;
    fb_wr_en          = 1'b0;
    fb_wr_x           = '0;
    fb_wr_y           = '0;
    fb_wr_colour      = '0;

    case (state_q)
      S_IDLE: begin
        if (screen_start) begin
          x_min_d   = screen_x_min;
          y_min_d   = screen_y_min;
          x_range_d = screen_x_range;
          y_range_d = screen_y_range;
          clear     = 1'b1;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        fb_rd_en = 1'b1;
        fb_rd_x  = cur_x[WIDTH-1:0];
        fb_rd_y  = cur_y[WIDTH-1:0];
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        // Coordinate is live this cycle and remembered so it holds until the next pixel.
        screen_x          = cur_x[WIDTH-1:0];
        screen_y          = cur_y[WIDTH-1:0];
        screen_x_d        = cur_x[WIDTH-1:0];
        screen_y_d        = cur_y[WIDTH-1:0];
        old_screen_colour = fb_rd_data;
        fb_wr_en          = in_screen;
        fb_wr_x           = cur_x[WIDTH-1:0];
        fb_wr_y           = cur_y[WIDTH-1:0];
        fb_wr_colour      = new_screen_colour;
        if (last) begin
          state_d = S_DONE;
        end else begin
          advance = 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE: begin
        screen_done = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_screen_rect_scanner.sv
// Randomised bench for screen_rect_scanner: framebuffer RAM, combinational client and a per-cycle reference model.
module tb_screen_rect_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       screen_start = 1'b0;
  logic [2:0] new_screen_colour;
  logic [7:0] screen_x_min = '0, screen_y_min = '0, screen_x_range = '0, screen_y_range = '0;
  logic [7:0] screen_x, screen_y;
  logic [2:0] old_screen_colour;
  logic       screen_done, busy;
  logic       fb_rd_en, fb_wr_en;
  logic [7:0] fb_rd_x, fb_rd_y, fb_wr_x, fb_wr_y;
  logic [2:0] fb_rd_data = '0;
  logic [2:0] fb_wr_colour;

  screen_rect_scanner dut (
    .clock             (clock),
    .reset             (reset),
    .screen_start      (screen_start),
    .new_screen_colour (new_screen_colour),
    .screen_x_min      (screen_x_min),
    .screen_y_min      (screen_y_min),
    .screen_x_range    (screen_x_range),
    .screen_y_range    (screen_y_range),
    .screen_x          (screen_x),
    .screen_y          (screen_y),
    .old_screen_colour (old_screen_colour),
    .screen_done       (screen_done),
    .busy              (busy),
    .fb_rd_en          (fb_rd_en),
    .fb_rd_x           (fb_rd_x),
    .fb_rd_y           (fb_rd_y),
    .fb_rd_data        (fb_rd_data),
    .fb_wr_en          (fb_wr_en),
    .fb_wr_x           (fb_wr_x),
    .fb_wr_y           (fb_wr_y),
    .fb_wr_colour      (fb_wr_colour)
  );

  always #5 clock = ~clock;

  typedef enum int {K_IDLE, K_READ, K_WRITE, K_DONE} kind_e;
  typedef struct { kind_e kind; int x; int y; } rec_t;

  rec_t exp_q[$];
  int   wlog_x[$], wlog_y[$], vlog[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, start_cyc = 0, done_cyc = -1, done_cnt = 0;
  bit   done_seen = 0, chk_en = 0;
  int   last_x = 0, last_y = 0;
  int   client_mode = 0;
  int   preload_mode = 0, preload_seed = 0;
  logic preload_req = 1'b0;
  logic [2:0] ram    [0:159][0:119];
  logic [2:0] ref_fb [0:159][0:119];

  int ex1_x[6] = '{10, 11, 12, 10, 11, 12};
  int ex1_y[6] = '{20, 20, 20, 21, 21, 21};

  function automatic logic [2:0] pat(int x, int y, int mode, int seed);
    case (mode)
      0:       return 3'b001;
      1:       return 3'((x ^ y) & 7);
      default: return 3'((x * 7 + y * 13 + seed) & 7);
    endcase
  endfunction

  // Client: mode 1 paints a checkerboard and echoes the old colour on the other squares.
  function automatic logic [2:0] client_fn(int x, int y, int old, int mode);
    case (mode)
      0:       return 3'b110;
      1:       return (((x + y) & 1) == 0) ? 3'b101 : 3'(old);
      default: return 3'((x + 2 * y + old + 1) & 7);
    endcase
  endfunction

  always_comb new_screen_colour = client_fn(int'(screen_x), int'(screen_y), int'(old_screen_colour), client_mode);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (preload_req) begin
      for (int x = 0; x < 160; x++)
        for (int y = 0; y < 120; y++)
          ram[x][y] <= pat(x, y, preload_mode, preload_seed);
    end else if (fb_wr_en && fb_wr_x < 8'd160 && fb_wr_y < 8'd120) begin
      ram[fb_wr_x][fb_wr_y] <= fb_wr_colour;
    end
    if (fb_rd_en)
      fb_rd_data <= (fb_rd_x < 8'd160 && fb_rd_y < 8'd120) ? ram[fb_rd_x][fb_rd_y] : 3'b000;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    rec_t r;
    int xl, yl, old_e, col_e;
    bit wr_e;
    if (chk_en) begin
      if (exp_q.size() > 0) r = exp_q.pop_front();
      else begin r.kind = K_IDLE; r.x = 0; r.y = 0; end
      xl = r.x % 256;
      yl = r.y % 256;
      check("busy", int'(busy), int'(r.kind != K_IDLE));
      check("screen_done", int'(screen_done), int'(r.kind == K_DONE));
      check("fb_rd_en", int'(fb_rd_en), int'(r.kind == K_READ));
      if (r.kind == K_READ) begin
        check("fb_rd_x", int'(fb_rd_x), xl);
        check("fb_rd_y", int'(fb_rd_y), yl);
      end
      if (r.kind == K_WRITE) begin
        old_e = (xl < 160 && yl < 120) ? int'(ref_fb[xl][yl]) : 0;
        wr_e  = (r.x < 160) && (r.y < 120);
        col_e = int'(client_fn(xl, yl, old_e, client_mode));
        check("screen_x", int'(screen_x), xl);
        check("screen_y", int'(screen_y), yl);
        check("old_colour", int'(old_screen_colour), old_e);
        check("fb_wr_en", int'(fb_wr_en), int'(wr_e));
        check("fb_wr_x", int'(fb_wr_x), xl);
        check("fb_wr_y", int'(fb_wr_y), yl);
        check("fb_wr_colour", int'(fb_wr_colour), col_e);
        if (wr_e) ref_fb[xl][yl] = 3'(col_e);
        last_x = xl;
        last_y = yl;
        vlog.push_back(int'(screen_x));
      end else begin
        check("screen_x_hold", int'(screen_x), last_x);
        check("screen_y_hold", int'(screen_y), last_y);
        check("old_colour_idle", int'(old_screen_colour), 0);
        check("fb_wr_en_idle", int'(fb_wr_en), 0);
      end
      if (screen_done) begin
        done_seen = 1;
        done_cyc  = cyc - start_cyc;
        done_cnt++;
      end
      if (fb_wr_en) begin
        wlog_x.push_back(int'(fb_wr_x));
        wlog_y.push_back(int'(fb_wr_y));
      end
    end
  end

  task automatic model_scan(input int xm, input int ym, input int xr, input int yr);
    for (int oy = 0; oy <= yr; oy++)
      for (int ox = 0; ox <= xr; ox++) begin
        exp_q.push_back('{kind: K_READ,  x: xm + ox, y: ym + oy});
        exp_q.push_back('{kind: K_WRITE, x: xm + ox, y: ym + oy});
      end
    exp_q.push_back('{kind: K_DONE, x: 0, y: 0});
  endtask

  task automatic scramble_inputs();
    screen_x_min   = 8'($urandom);
    screen_y_min   = 8'($urandom);
    screen_x_range = 8'($urandom);
    screen_y_range = 8'($urandom);
  endtask

  task automatic check_zero(input string tag);
    int z;
    z = int'(screen_x) | int'(screen_y) | int'(old_screen_colour) | int'(screen_done) | int'(busy)
      | int'(fb_rd_en) | int'(fb_wr_en) | int'(fb_rd_x) | int'(fb_rd_y) | int'(fb_wr_x)
      | int'(fb_wr_y) | int'(fb_wr_colour);
    check(tag, z, 0);
  endtask

  task automatic do_preload(input int mode, input int seed);
    @(negedge clock); #1;
    preload_mode = mode;
    preload_seed = seed;
    preload_req  = 1'b1;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        ref_fb[x][y] = pat(x, y, mode, seed);
    @(negedge clock); #1;
    preload_req = 1'b0;
  endtask

  task automatic ram_check(input string tag);
    int bad = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        if (ram[x][y] !== ref_fb[x][y]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic run_scan(input int xm, input int ym, input int xr, input int yr,
                          input int exp_cyc, input int exp_wr, input bit scramble);
    int n, lim;
    @(negedge clock); #1;
    screen_x_min   = 8'(xm);
    screen_y_min   = 8'(ym);
    screen_x_range = 8'(xr);
    screen_y_range = 8'(yr);
    screen_start   = 1'b1;
    start_cyc = cyc;
    done_seen = 0;
    done_cyc  = -1;
    wlog_x.delete(); wlog_y.delete(); vlog.delete();
    model_scan(xm, ym, xr, yr);
    lim = 2 * (xr + 1) * (yr + 1) + 20;
    n = 0;
    while (!done_seen && n < lim) begin
      @(negedge clock); #1;
      screen_start = 1'b0;
      if (scramble) scramble_inputs();
      n++;
    end
    check("done_reached", int'(done_seen), 1);
    check("done_cycle", done_cyc, exp_cyc);
    check("write_count", wlog_x.size(), exp_wr);
    if (!done_seen) exp_q.delete();
  endtask

  initial begin
    int xm, ym, xr, yr, nw, d0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check_zero("reset_outputs");
    reset  = 1'b0;
    chk_en = 1;

    // Basic 3x2 rectangle, constant client colour.
    do_preload(0, 0);
    client_mode = 0;
    run_scan(10, 20, 2, 1, 13, 6, 1'b0);
    for (int i = 0; i < 6 && i < wlog_x.size(); i++) begin
      check("t1_write_x", wlog_x[i], ex1_x[i]);
      check("t1_write_y", wlog_y[i], ex1_y[i]);
    end

    // Single pixel.
    run_scan(0, 0, 0, 0, 3, 1, 1'b0);

    // Clipping at the bottom-right corner.
    run_scan(158, 118, 3, 3, 33, 4, 1'b0);
    check("t3_visited", vlog.size(), 16);

    // Coordinate overflow past 255 wraps screen_x but never writes.
    run_scan(250, 5, 10, 0, 23, 0, 1'b1);
    check("t4_visited", vlog.size(), 11);
    if (vlog.size() == 11) begin
      check("t4_first_x", vlog[0], 250);
      check("t4_wrap_x", vlog[6], 0);
      check("t4_last_x", vlog[10], 4);
    end

    // Echoing client over a patterned framebuffer.
    do_preload(1, 0);
    client_mode = 1;
    run_scan(20, 30, 6, 5, 85, 42, 1'b1);
    @(negedge clock);
    check("t5_ram_20_30", int'(ram[20][30]), 5);
    check("t5_ram_21_30", int'(ram[21][30]), 3);
    ram_check("t5_ram_vs_model");

    // Start held through DONE restarts immediately.
    client_mode = 2;
    d0 = done_cnt;
    @(negedge clock); #1;
    screen_x_min = 8'd40; screen_y_min = 8'd50; screen_x_range = 8'd1; screen_y_range = 8'd0;
    screen_start = 1'b1;
    model_scan(40, 50, 1, 0);
    exp_q.push_back('{kind: K_IDLE, x: 0, y: 0});
    model_scan(40, 50, 1, 0);
    repeat (7) @(negedge clock);
    #1 screen_start = 1'b0;
    repeat (6) @(negedge clock);
    check("restart_done_count", done_cnt - d0, 2);

    // Reset mid-scan on the third pixel of a 3x3.
    do_preload(2, 5);
    @(negedge clock); #1;
    screen_x_min = 8'd30; screen_y_min = 8'd40; screen_x_range = 8'd2; screen_y_range = 8'd2;
    screen_start = 1'b1;
    model_scan(30, 40, 2, 2);
    @(negedge clock); #1;
    screen_start = 1'b0;
    d0 = done_cnt;
    repeat (4) @(negedge clock);
    #1;
    check("reset_at_pixel3_reading", int'(fb_rd_en), 1);
    reset = 1'b1;
    exp_q.delete();
    last_x = 0;
    last_y = 0;
    @(negedge clock); #1;
    check_zero("midscan_reset_outputs");
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("no_done_after_reset", done_cnt - d0, 0);
    run_scan(30, 40, 2, 2, 19, 9, 1'b0);
    @(negedge clock);
    ram_check("t6_ram_vs_model");

    // Randomised rectangles, many near the screen edges.
    for (int it = 0; it < 14; it++) begin
      client_mode = $urandom_range(0, 2);
      xm = ($urandom_range(0, 1) == 1) ? $urandom_range(150, 255) : $urandom_range(0, 159);
      ym = ($urandom_range(0, 1) == 1) ? $urandom_range(110, 255) : $urandom_range(0, 119);
      xr = $urandom_range(0, 6);
      yr = $urandom_range(0, 4);
      nw = 0;
      for (int oy = 0; oy <= yr; oy++)
        for (int ox = 0; ox <= xr; ox++)
          if (xm + ox < 160 && ym + oy < 120) nw++;
      run_scan(xm, ym, xr, yr, 2 * (xr + 1) * (yr + 1) + 1, nw, 1'b1);
    end
    @(negedge clock);
    ram_check("final_ram_vs_model");
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
